// File: rtl/ps2_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_cmd_ctrl
//
// Host-side PS/2 controller. It sends one host-to-device command byte at a
// time (inhibit, request-to-send, ten device-clocked bits, device ACK), then
// collects the device's one-byte response. Frames that arrive while no
// command is in flight are reported as unsolicited data (scan codes) after
// framing and odd-parity checks.
//
// Optional build macro:
//   PS2_AUTO_RETRY_EN - when defined, a 0xFE (resend) response re-sends the
//                       latched command up to MAX_RETRY times before the
//                       command is reported as failed.
//
// Ports:
//   CLOCK_50    in   system clock, all logic on the rising edge
//   Resetn      in   synchronous active-low reset
//   ps2_clk_in  in   raw pad level of ps2_clk (asynchronous)
//   ps2_dat_in  in   raw pad level of ps2_dat (asynchronous)
//   ps2_clk_oe  out  1 = pull ps2_clk low, 0 = release
//   ps2_dat_oe  out  1 = pull ps2_dat low, 0 = release
//   cmd_valid   in   command request
//   cmd_byte    in   command byte to send
//   cmd_ready   out  high only while idle
//   done        out  one-cycle pulse, command finished
//   done_ok     out  with done: 1 = device answered 0xFA
//   resp_byte   out  with done: response byte (0x00 on timeout)
//   rx_valid    out  one-cycle pulse, good unsolicited frame
//   rx_byte     out  with rx_valid: received data
//   rx_err      out  one-cycle pulse, unsolicited frame failed framing/parity
//   state_dbg   out  current FSM state (debug)
//   retry_dbg   out  resends used for the current command (debug)
//
// Handshake: a command is accepted on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_byte must be stable in that cycle. cmd_valid
// while cmd_ready is low is ignored and nothing is queued.
// -----------------------------------------------------------------------------
module ps2_cmd_ctrl #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GAP_CYCLES     = 100000,
    parameter int MAX_RETRY      = 2,
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               CLOCK_50,
    input  logic               Resetn,
    input  logic               ps2_clk_in,
    input  logic               ps2_dat_in,
    output logic               ps2_clk_oe,
    output logic               ps2_dat_oe,
    input  logic               cmd_valid,
    input  logic [7:0]         cmd_byte,
    output logic               cmd_ready,
    output logic               done,
    output logic               done_ok,
    output logic [7:0]         resp_byte,
    output logic               rx_valid,
    output logic [7:0]         rx_byte,
    output logic               rx_err,
    output logic [2:0]         state_dbg,
    output logic [RETRY_W-1:0] retry_dbg
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_TX        = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_RESP = 3'd5;

    logic [2:0]         state;
    logic               clk_s1, clk_s2, clk_prev;
    logic               dat_s1, dat_s2;
    logic [INH_W-1:0]   inh_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [9:0]         rx_shift;
    logic [3:0]         rx_cnt;
    logic [3:0]         tx_idx;
    logic [8:0]         tx_data;     // {odd parity, command byte}
    logic [RETRY_W-1:0] retry_cnt;

    logic        fall;
    logic        rx_en;
    logic        to_active;
    logic        timeout_hit;
    logic [10:0] frame_w;
    logic        frame_done;
    logic        frame_ok;
    logic [7:0]  frame_data;

    assign fall = clk_prev & ~clk_s2;

    // The receiver only listens when the device owns the data line; during
    // REQ/TX/ACK the edges belong to the outgoing command.
    assign rx_en = (state == S_IDLE) | (state == S_INHIBIT) | (state == S_WAIT_RESP);

    assign to_active = (state == S_REQ) | (state == S_TX) |
                       (state == S_ACK) | (state == S_WAIT_RESP);

    // A falling edge restarts the timeout, so it wins over an expiry.
    assign timeout_hit = to_active & ~fall & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // The 11th bit is still on the synchronizer; the first ten are shifted in.
    assign frame_w    = {dat_s2, rx_shift};
    assign frame_done = rx_en & fall & (rx_cnt == 4'd10);
    assign frame_ok   = ~frame_w[0] & frame_w[10] & (^frame_w[9:1]);
    assign frame_data = frame_w[8:1];

    assign cmd_ready = (state == S_IDLE);
    assign state_dbg = state;
    assign retry_dbg = retry_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state      <= S_IDLE;
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            clk_prev   <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            rx_shift   <= '0;
            rx_cnt     <= '0;
            tx_idx     <= '0;
            tx_data    <= '0;
            retry_cnt  <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b0;
            done_ok    <= 1'b0;
            resp_byte  <= '0;
            rx_valid   <= 1'b0;
            rx_byte    <= '0;
            rx_err     <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat_in;
            dat_s2   <= dat_s1;

            done     <= 1'b0;
            done_ok  <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;

            // Receiver: shift on falling edges, drop a partial frame after a
            // long idle gap so a glitch cannot misalign the next frame.
            if (!rx_en) begin
                rx_cnt  <= '0;
                gap_cnt <= '0;
            end else if (fall) begin
                gap_cnt <= '0;
                if (rx_cnt == 4'd10) begin
                    rx_cnt <= '0;
                end else begin
                    rx_cnt   <= rx_cnt + 4'd1;
                    rx_shift <= {dat_s2, rx_shift[9:1]};
                end
            end else if (rx_cnt != 4'd0) begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    rx_cnt  <= '0;
                    gap_cnt <= '0;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end

            // Frames completing while a response is awaited belong to the
            // command, never to the unsolicited stream.
            if (frame_done && (state != S_WAIT_RESP)) begin
                rx_valid <= frame_ok;
                rx_err   <= ~frame_ok;
                if (frame_ok) begin
                    rx_byte <= frame_data;
                end
            end

            if (!to_active || fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        tx_data    <= {~^cmd_byte, cmd_byte};
                        retry_cnt  <= '0;
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        rx_cnt     <= '0;
                        gap_cnt    <= '0;
                        state      <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    // Data goes low while the clock is still held so the
                    // device sees the start bit as soon as the clock releases.
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        ps2_dat_oe <= 1'b1;
                        state      <= S_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                S_REQ: begin
                    ps2_clk_oe <= 1'b0;
                    tx_idx     <= '0;
                    state      <= S_TX;
                end

                S_TX: begin
                    if (fall) begin
                        if (tx_idx == 4'd9) begin
                            ps2_dat_oe <= 1'b0;
                            state      <= S_ACK;
                        end else begin
                            ps2_dat_oe <= ~tx_data[tx_idx];
                            tx_idx     <= tx_idx + 4'd1;
                        end
                    end
                end

                S_ACK: begin
                    if (fall) begin
                        if (!dat_s2) begin
                            state <= S_WAIT_RESP;
                        end else begin
                            done      <= 1'b1;
                            resp_byte <= 8'h00;
                            state     <= S_IDLE;
                        end
                    end
                end

                S_WAIT_RESP: begin
                    if (frame_done) begin
                        if (frame_ok && (frame_data == 8'hFA)) begin
                            done      <= 1'b1;
                            done_ok   <= 1'b1;
                            resp_byte <= frame_data;
                            state     <= S_IDLE;
                        end
`ifdef PS2_AUTO_RETRY_EN
                        else if (frame_ok && (frame_data == 8'hFE) &&
                                 (retry_cnt < RETRY_W'(MAX_RETRY))) begin
                            retry_cnt  <= retry_cnt + 1'b1;
                            inh_cnt    <= '0;
                            ps2_clk_oe <= 1'b1;
                            rx_cnt     <= '0;
                            gap_cnt    <= '0;
                            state      <= S_INHIBIT;
                        end
`endif
                        else begin
                            done      <= 1'b1;
                            resp_byte <= frame_data;
                            state     <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (timeout_hit) begin
                done       <= 1'b1;
                done_ok    <= 1'b0;
                resp_byte  <= 8'h00;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                state      <= S_IDLE;
            end
        end
    end

endmodule

// File: doc/ps2_cmd_ctrl.md
Name: ps2_cmd_ctrl

Overview:
Host-side PS/2 controller that sequences host-to-device command transmission (e.g. 0xED set-LEDs, 0xFF reset) over the bidirectional ps2_clk/ps2_dat lines, then collects the device's response byte. Also delivers unsolicited device frames (scan codes) with framing and parity checking. Sits between board-level open-drain PS/2 pads and user logic; only one command is in flight at a time.

Parameters:
INHIBIT_CYCLES, 5000, cycles ps2_clk is held low before request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, max cycles waiting for device clocking or response (20 ms)
GAP_CYCLES, 100000, idle cycles after which a partial receive frame is discarded (2 ms)
MAX_RETRY, 2, resend attempts after 0xFE (only with PS2_AUTO_RETRY_EN)

Ports:
CLOCK_50 in 1 system clock, all logic on rising edge
Resetn in 1 synchronous active-low reset
ps2_clk_in in 1 raw pad level of ps2_clk (asynchronous)
ps2_dat_in in 1 raw pad level of ps2_dat (asynchronous)
ps2_clk_oe out 1 1 = drive ps2_clk low, 0 = release
ps2_dat_oe out 1 1 = drive ps2_dat low, 0 = release
cmd_valid in 1 command request
cmd_byte in 8 command to send
cmd_ready out 1 high in IDLE only; command accepted when cmd_valid & cmd_ready
done out 1 one-cycle pulse: command finished
done_ok out 1 valid with done: 1 = response 0xFA received
resp_byte out 8 response byte, valid with done
rx_valid out 1 one-cycle pulse: unsolicited frame received
rx_byte out 8 received data, valid with rx_valid
rx_err out 1 one-cycle pulse: framing or parity error on a received frame

Behaviour:
- Reset (Resetn=0 at clock edge): state IDLE, all outputs 0 except cmd_ready=1; counters, shift registers and retry count cleared; pads released. Reset mid-transfer releases both lines on the next edge.
- Inputs pass through 2-flop synchronizers (reset to 1). Falling edge = synced prev 1, now 0. Edge-detect latency: 3 cycles from pad.
- Receiver: on each falling edge, shift ps2_dat into an 11-bit frame, LSB first (start, d0..d7, parity, stop). At 11 bits: start=0, stop=1 and odd parity over d0..d7+parity, otherwise error. Bit count clears after GAP_CYCLES with no edge, and on entering INHIBIT.
- FSM states:
  - IDLE: on handshake latch cmd_byte, compute odd parity, retry=0 -> INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES -> REQ.
  - REQ: dat_oe=1 (start bit), clk_oe=0 -> TX. Timeout counter starts.
  - TX: on each falling edge present next bit: dat_oe = ~bit for d0..d7, parity. On 10th edge release dat (stop) -> ACK.
  - ACK: wait falling edge with synced dat=0 -> WAIT_RESP. If dat=1 on that edge, error.
  - WAIT_RESP: receiver frame completes -> evaluate.
  - Evaluate: 0xFA, good frame -> done=1, done_ok=1. 0xFE -> retry (see Optional Feature). Anything else or bad frame -> done=1, done_ok=0. resp_byte = received data. Then IDLE.
- Timeout: the counter resets on every falling edge in REQ/TX/ACK/WAIT_RESP. Reaching TIMEOUT_CYCLES gives done=1, done_ok=0, resp_byte=0x00, lines released, IDLE.
- Frames completing in IDLE or INHIBIT: rx_valid (good) or rx_err (bad). Frames completing in WAIT_RESP go only to resp_byte, never rx_valid/rx_err.
- cmd_valid outside IDLE is ignored; no queueing.
- done and rx_valid never assert in the same cycle.

Optional Feature:
PS2_AUTO_RETRY_EN:
- Defined: 0xFE response with retry<MAX_RETRY increments retry and returns to INHIBIT, resending the latched byte with no done pulse. When retries are exhausted: done=1, done_ok=0, resp_byte=0xFE.
- Undefined: 0xFE ends immediately with done=1, done_ok=0, resp_byte=0xFE. MAX_RETRY is unused.

Test Plan:
- Device sends frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 10 kHz while IDLE -> rx_valid one pulse, rx_byte=0x1C, rx_err=0.
- Same frame with parity flipped to 1 -> rx_err pulse, no rx_valid.
- cmd_byte=0xED; device model clocks, acks, replies 0xFA -> clk_oe low ≥5000 cycles, bits on dat_oe = 1,0,1,1,0,1,1,1, parity 1 (dat_oe=0). done=1, done_ok=1, resp_byte=0xFA.
- cmd_byte=0xFF; device model never clocks -> done at TIMEOUT_CYCLES after REQ, done_ok=0, resp_byte=0x00, both oe=0, cmd_ready=1.
- With PS2_AUTO_RETRY_EN: device replies 0xFE, 0xFE, then 0xFA -> 3 INHIBIT phases, single done, done_ok=1. Without the macro: first 0xFE -> done, done_ok=0, resp_byte=0xFE.
- Resetn=0 asserted in TX after 4 bits -> next edge: oe both 0, cmd_ready=1. A following 0xF4 command completes normally.
